regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug read-out engine on the register-file read side of the RV32I pipeline. On a start pulse it freezes the core, walks every register address through a dedicated read port, and emits each {index, value} pair on a valid/ready stream. Testbenches and on-chip debug logic use it to capture a consistent architectural snapshot. It is the consumer counterpart of the writeback port that fills the register file.

## Interface
- D_WIDTH, 32, register data width
- A_WIDTH, 5, register address width; N_REGS = 1 << A_WIDTH registers dumped
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle dump request; ignored while busy
- raddr  out  A_WIDTH  address driven to a register-file read port
- rdata  in  D_WIDTH  combinational read data for raddr, same cycle
- stall_req  out  1  freeze request to the core pipeline; high while busy
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts word
- out_index  out  A_WIDTH  register number of current word
- out_data  out  D_WIDTH  register value of current word
- out_last  out  1  current word is register N_REGS-1
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Reset values: state IDLE, ptr 0, raddr 0, stall_req 0, busy 0, out_valid 0, out_index 0, out_data 0, out_last 0, done 0.
- States:
  - IDLE: start=1 -> READ; ptr <= 0.
  - READ: raddr = ptr. If out_valid=0 or out_ready=1, load {ptr, rdata, ptr==N_REGS-1} into the output register and set out_valid. If ptr==N_REGS-1, go to DRAIN; otherwise ptr <= ptr+1. If the output register is blocked, hold ptr; raddr stays stable.
  - DRAIN: out_valid=1 and out_ready=1 -> clear out_valid and go to IDLE. done pulses in the first IDLE cycle.
- busy = stall_req = (state != IDLE), decoded from registered state, so there is no combinational path from start.
- The stream payload (out_index, out_data, out_last) stays stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on rst.
- ptr is A_WIDTH bits wide. The terminal compare is against N_REGS-1, so the counter never wraps past the end. Register 0 is read like any other register and is not special-cased.
- Consistency: the core must hold wen low while stall_req=1. This block does not check that.
- Simultaneous events:
  - A start in the same cycle as done is accepted and begins a new dump.
  - start during READ or DRAIN has no effect.
- rst mid-dump: immediate return to reset values. The partial stream is discarded, done is not pulsed, and stall_req drops on the next cycle.

## Timing
- Edges are numbered from E0, the edge that samples start=1. busy and stall_req go high after E0.
- With out_ready held at 1:
  - word k is valid after edge E(k+1);
  - out_last is valid after E(N_REGS);
  - DRAIN handshake completes at E(N_REGS+1); done is high for the cycle after it.
- Throughput is one word per cycle. Backpressure adds exactly the number of stalled cycles.
- rdata is sampled at the rising edge. The register file writes on the falling edge, so a write from half a cycle earlier is visible.
- Minimum dump length is N_REGS+1 cycles of busy.

## Structure
- Package regfile_dump_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - default D_WIDTH and A_WIDTH constants shared with the register file.
- Sub-module stream_out_reg holds the output register: a single-entry register with valid/ready, load enable = !out_valid | out_ready, parameterised payload width. The FSM and pointer stay in regfile_dump_reader.

## Test plan
- Preload register k = 32'hA000_0000+k, pulse start, hold out_ready=1:
  - 32 words arrive in consecutive cycles with index 0..31 and matching data;
  - out_last is set only on index 31;
  - done pulses one cycle after that handshake.
- Same dump with out_ready toggling 1,0,0,1,…:
  - no word is lost or duplicated;
  - payload is stable while stalled;
  - total time = 33 cycles + number of stall cycles.
- Pulse start again at cycles 3 and 10 of a dump: stream unchanged and only one done pulse. Then start coincident with done: a second full 32-word dump follows.
- Assert rst during word 12 with out_valid=1 and out_ready=0:
  - next cycle: out_valid=0, busy=0, stall_req=0, raddr=0;
  - no done pulse.
- After reset, hold start=0 for 100 cycles: out_valid, busy and done stay at 0.
- Preload register 31 = 32'hFFFF_FFFF and register 0 = 32'h0, then dump: word 31 carries 32'hFFFF_FFFF and word 0 carries 0.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump reader and the
// register file it reads from.
package regfile_dump_pkg;

    localparam int D_WIDTH_DEF = 32;
    localparam int A_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying one {index, value, last} word per register.
interface regfile_dump_reader_if
    import regfile_dump_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
);

    logic               out_valid;
    logic               out_ready;
    logic [A_WIDTH-1:0] out_index;
    logic [D_WIDTH-1:0] out_data;
    logic               out_last;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump_reader_stream_out_reg.sv
// Single-entry valid/ready output register; accepts a new word whenever it is
// empty or its current word is being consumed in the same cycle.
module stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             load_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        load_en = !valid_q || out_ready;
        if (load_en) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // NOTE: non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: freezes the core and streams every register as an
// {index, value, last} word through a valid/ready output register.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [A_WIDTH-1:0]    raddr,
    input  logic [D_WIDTH-1:0]    rdata,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    regfile_dump_reader_if.master dump_out
);

    localparam int                 N_REGS   = 1 << A_WIDTH;
    localparam int                 PW       = A_WIDTH + D_WIDTH + 1;
    localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(N_REGS - 1);

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] ptr_q, ptr_d;
    logic               done_q, done_d;

    logic               load_en;
    logic               word_valid;
    logic [PW-1:0]      word_in;
    logic [PW-1:0]      word_out;
    logic               out_valid_w;

    assign word_valid = (state_q == READ);
    assign word_in    = {ptr_q, rdata, ptr_q == LAST_IDX};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    ptr_d   = '0;
                end
            end
            READ: begin
                // Pointer only moves when the output register takes the word.
                if (load_en) begin
                    if (ptr_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        ptr_d = ptr_q + A_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_valid_w && dump_out.out_ready) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    stream_out_reg #(
        .WIDTH(PW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (word_valid),
        .in_data   (word_in),
        .load_en   (load_en),
        .out_valid (out_valid_w),
        .out_ready (dump_out.out_ready),
        .out_data  (word_out)
    );

    assign dump_out.out_valid = out_valid_w;
    assign dump_out.out_index = word_out[PW-1 -: A_WIDTH];
    assign dump_out.out_data  = word_out[D_WIDTH:1];
    assign dump_out.out_last  = word_out[0];

    // Decoded from registered state only: start never reaches these outputs.
    assign busy      = (state_q != IDLE);
    assign stall_req = busy;
    assign raddr     = ptr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words are queued when a
// dump is started and popped on every observed handshake.
module tb_regfile_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;
    localparam int PW = AW + DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          stall_req;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NR];

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] exp_q [$];

    regfile_dump_reader_if #(.D_WIDTH(DW), .A_WIDTH(AW)) dump_if ();

    regfile_dump_reader #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .raddr     (raddr),
        .rdata     (rdata),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .dump_out  (dump_if)
    );

    always #5 clk = ~clk;

    assign rdata = regs[raddr];

    function automatic logic [PW-1:0] cur_payload();
        return {dump_if.out_index, dump_if.out_data, dump_if.out_last};
    endfunction

    function automatic bit ready_for(input int mode, input int cyc);
        if (mode == 1) return (cyc % 3) == 0;
        return 1'b1;
    endfunction

    task automatic push_expected();
        for (int k = 0; k < NR; k++) begin
            exp_q.push_back({AW'(k), regs[k], (k == NR - 1)});
        end
    endtask

    // Runs one dump from the start pulse to the done pulse, checking every word.
    task automatic run_dump(input string name, input int mode, input bit restarts,
                            input bit chain_next, input bit pre_started);
        int cyc = 0;
        int words = 0;
        int stalls = 0;
        int busy_cycles = 0;
        bit stalled = 0;
        bit last_hs = 0;
        bit finished = 0;
        logic [PW-1:0] held;
        logic [PW-1:0] got;
        logic [PW-1:0] exp;
        push_expected();
        if (!pre_started) start = 1'b1;
        dump_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && cyc < 1000) begin
            if (busy) busy_cycles++;
            checks++;
            if (busy !== !last_hs || stall_req !== !last_hs) begin
                errors++;
                $display("FAIL %s busy/stall cyc %0d: got %b/%b, want %b", name, cyc, busy, stall_req, !last_hs);
            end
            if (last_hs) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done pulse: got %b, want 1", name, done);
                end
                finished = 1;
                if (chain_next) start = 1'b1;
            end else begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early done cyc %0d: got %b, want 0", name, cyc, done);
                end
                if (stalled) begin
                    checks++;
                    if (dump_if.out_valid !== 1'b1 || cur_payload() !== held) begin
                        errors++;
                        $display("FAIL %s stall stability cyc %0d: got v=%b %h, want v=1 %h", name, cyc, dump_if.out_valid, cur_payload(), held);
                    end
                end
                dump_if.out_ready = ready_for(mode, cyc);
                start = restarts && (cyc == 3 || cyc == 10);
                stalled = 0;
                if (dump_if.out_valid === 1'b1 && dump_if.out_ready) begin
                    got = cur_payload();
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra word: got %h, want none", name, got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL %s word %0d: got %h, want %h", name, words, got, exp);
                        end
                        if (exp[0]) last_hs = 1;
                    end
                    words++;
                end else if (dump_if.out_valid === 1'b1) begin
                    stalls++;
                    stalled = 1;
                    held = cur_payload();
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
        end
        checks++;
        if (words != NR || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s word count: got %0d (left %0d), want %0d", name, words, exp_q.size(), NR);
        end
        checks++;
        if (busy_cycles != NR + 1 + stalls) begin
            errors++;
            $display("FAIL %s duration: got %0d busy cycles, want %0d", name, busy_cycles, NR + 1 + stalls);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dump_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({raddr, stall_req, busy, done} !== '0 ||
            {dump_if.out_valid, dump_if.out_index, dump_if.out_data, dump_if.out_last} !== '0) begin
            errors++;
            $display("FAIL reset values: got raddr=%h stall=%b busy=%b done=%b v=%b idx=%h data=%h last=%b, want all 0",
                     raddr, stall_req, busy, done, dump_if.out_valid, dump_if.out_index, dump_if.out_data, dump_if.out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        run_dump("full_dump", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_dump("backpressure", 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_restart_ignored();
        run_dump("restart_ignored", 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored after done: got done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_start_on_done();
        run_dump("chain_first", 0, 1'b0, 1'b1, 1'b0);
        run_dump("chain_second", 1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_dump();
        bit hit = 0;
        logic [PW-1:0] exp;
        push_expected();
        start = 1'b1;
        dump_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (dump_if.out_valid === 1'b1 && dump_if.out_index == AW'(12)) begin
                hit = 1;
                dump_if.out_ready = 1'b0;
                rst = 1'b1;
            end else begin
                if (dump_if.out_valid === 1'b1) begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (cur_payload() !== exp) begin
                        errors++;
                        $display("FAIL reset_mid word: got %h, want %h", cur_payload(), exp);
                    end
                end
                @(negedge clk);
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid reach word 12: got no word 12, want word 12");
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dump_if.out_valid !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0 || raddr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid state: got v=%b busy=%b stall=%b raddr=%h done=%b, want all 0",
                     dump_if.out_valid, busy, stall_req, raddr, done);
        end
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid no done: got done=%b busy=%b, want 0/0", done, busy);
            end
        end
        dump_if.out_ready = 1'b1;
    endtask

    task automatic test_idle_after_reset();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            checks++;
            if ({dump_if.out_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL idle cyc %0d: got valid/busy/done=%b, want 000", c, {dump_if.out_valid, busy, done});
            end
        end
    endtask

    task automatic test_boundary_values();
        regs[NR - 1] = 32'hFFFF_FFFF;
        regs[0]      = 32'h0000_0000;
        run_dump("boundary_values", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dump_if.out_ready = 1'b0;
        for (int k = 0; k < NR; k++) begin
            regs[k] = 32'hA000_0000 + 32'(k);
        end
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart_ignored();
        test_start_on_done();
        test_reset_mid_dump();
        test_idle_after_reset();
        test_boundary_values();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
